// File: rtl/mac_kbd_host.sv
// rtl/mac_kbd_host.sv - host-side Mac Plus keyboard serial controller
//
// Ports:
//   clk          16 MHz system clock
//   _reset       asynchronous active-low reset
//   clk8_en_p    8 MHz enable; timeout counter advances only on it
//   cmd_data     command byte to send
//   cmd_strobe   one-clk start pulse, ignored while busy
//   resp_data    last received response byte
//   resp_strobe  one-clk pulse when resp_data updates
//   timeout      one-clk pulse when a transaction is aborted
//   busy         high from accepted cmd_strobe until back in IDLE
//   kbd_clk_i    keyboard clock pin (asynchronous, keyboard-driven)
//   kbd_data_i   keyboard data pin (asynchronous)
//   kbd_data_oe  1 = pull data pin low, 0 = release
module mac_kbd_host #(
    parameter int REQ_TIMEOUT  = 40000,
    parameter int BIT_TIMEOUT  = 8000,
    parameter int RESP_TIMEOUT = 4000000
) (
    input  logic       clk,
    input  logic       _reset,
    input  logic       clk8_en_p,
    input  logic [7:0] cmd_data,
    input  logic       cmd_strobe,
    output logic [7:0] resp_data,
    output logic       resp_strobe,
    output logic       timeout,
    output logic       busy,
    input  logic       kbd_clk_i,
    input  logic       kbd_data_i,
    output logic       kbd_data_oe
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_TX, S_TURN, S_RX, S_ABORT
    } state_t;

    localparam logic [21:0] REQ_LIM  = REQ_TIMEOUT[21:0];
    localparam logic [21:0] BIT_LIM  = BIT_TIMEOUT[21:0];
    localparam logic [21:0] RESP_LIM = RESP_TIMEOUT[21:0];

    state_t      state, state_n;
    logic [2:0]  clk_sync;      // [1:0] synchronizer, [2] previous value for edge detect
    logic [1:0]  dat_sync;
    logic [7:0]  sr, sr_n;
    logic [3:0]  bc, bc_n;
    logic [21:0] tcnt, tcnt_n;
    logic [21:0] limit;
    logic        oe, oe_n;
    logic [7:0]  resp_data_n;
    logic        resp_strobe_n;
    logic        fall, rise, data_s, expire;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            clk_sync <= 3'b111;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[1:0], kbd_clk_i};
            dat_sync <= {dat_sync[0], kbd_data_i};
        end
    end

    assign fall   = ~clk_sync[1] &  clk_sync[2];
    assign rise   =  clk_sync[1] & ~clk_sync[2];
    assign data_s =  dat_sync[1];

    always_comb begin
        limit = '1;
        case (state)
            S_REQ:       limit = REQ_LIM;
            S_TX, S_RX:  limit = BIT_LIM;
            S_TURN:      limit = RESP_LIM;
            default:     limit = '1;
        endcase
    end

    // A clock edge in the same cycle as expiry wins: the edge is serviced.
    assign expire = (tcnt >= limit) && !fall && !rise;

    always_comb begin
        state_n       = state;
        sr_n          = sr;
        bc_n          = bc;
        oe_n          = oe;
        resp_data_n   = resp_data;
        resp_strobe_n = 1'b0;
        case (state)
            S_IDLE: begin
                oe_n = 1'b0;
                if (cmd_strobe) begin
                    sr_n    = cmd_data;
                    bc_n    = 4'd0;
                    oe_n    = 1'b1;            // hold data low: request to send
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                // A rise here is ignored; only the first fall starts the byte.
                if (fall) begin
                    oe_n    = ~sr[7];
                    sr_n    = {sr[6:0], 1'b0};
                    state_n = S_TX;
                end else if (expire) begin
                    oe_n    = 1'b0;
                    state_n = S_ABORT;
                end
            end
            S_TX: begin
                if (rise) begin
                    bc_n = bc + 4'd1;
                    if (bc == 4'd7) begin
                        oe_n    = 1'b0;        // release line for the response
                        state_n = S_TURN;
                    end
                end else if (fall && !bc[3]) begin
                    oe_n = ~sr[7];
                    sr_n = {sr[6:0], 1'b0};
                end else if (expire) begin
                    oe_n    = 1'b0;
                    state_n = S_ABORT;
                end
            end
            S_TURN: begin
                oe_n = 1'b0;
                if (fall) begin
                    bc_n    = 4'd0;
                    state_n = S_RX;
                end else if (expire) begin
                    state_n = S_ABORT;
                end
            end
            S_RX: begin
                oe_n = 1'b0;
                if (rise) begin
                    sr_n = {sr[6:0], data_s};
                    bc_n = bc + 4'd1;
                    if (bc == 4'd7) begin
                        resp_data_n   = {sr[6:0], data_s};
                        resp_strobe_n = 1'b1;
                        state_n       = S_IDLE;
                    end
                end else if (expire) begin
                    state_n = S_ABORT;
                end
            end
            S_ABORT: begin
                oe_n    = 1'b0;
                state_n = S_IDLE;
            end
            default: begin
                oe_n    = 1'b0;
                state_n = S_IDLE;
            end
        endcase

        if ((state_n != state) || fall || rise)
            tcnt_n = 22'd0;
        else if (clk8_en_p && (tcnt != '1))
            tcnt_n = tcnt + 22'd1;
        else
            tcnt_n = tcnt;
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state       <= S_IDLE;
            sr          <= 8'h00;
            bc          <= 4'd0;
            tcnt        <= 22'd0;
            oe          <= 1'b0;
            resp_data   <= 8'h00;
            resp_strobe <= 1'b0;
        end else begin
            state       <= state_n;
            sr          <= sr_n;
            bc          <= bc_n;
            tcnt        <= tcnt_n;
            oe          <= oe_n;
            resp_data   <= resp_data_n;
            resp_strobe <= resp_strobe_n;
        end
    end

    assign busy        = (state != S_IDLE);
    assign timeout     = (state == S_ABORT);
    assign kbd_data_oe = oe;

endmodule

// File: doc/mac_kbd_host.md
# mac_kbd_host

Host-side (Macintosh-end) controller for the Mac Plus keyboard serial protocol. The keyboard generates the clock on this link; the host only drives or releases the data line. The block takes a command byte from the core, signals request-to-send, and shifts the byte out on keyboard-generated clocks. It then turns the line around, shifts in the 8-bit response and hands it back with a strobe. It sits between core logic and the external keyboard pins, mirroring the keyboard-side emulation inside the data controller.

## Interface
Parameters:
- REQ_TIMEOUT, 40000: clk8_en_p ticks to wait for the first keyboard clock fall after request (5 ms).
- BIT_TIMEOUT, 8000: maximum clk8_en_p ticks between consecutive clock edges inside a byte (1 ms).
- RESP_TIMEOUT, 4000000: maximum clk8_en_p ticks from end of command to first response clock fall (0.5 s).

Ports:
- clk  in  1  16 MHz system clock; the only clock.
- _reset  in  1  asynchronous, active-low reset.
- clk8_en_p  in  1  8 MHz enable; timeout counters advance only on it.
- cmd_data  in  8  command byte to send.
- cmd_strobe  in  1  one-clk pulse that starts a transaction; ignored while busy=1.
- resp_data  out  8  last received response byte, held until the next successful receive.
- resp_strobe  out  1  one-clk pulse when resp_data is updated.
- timeout  out  1  one-clk pulse when a transaction is aborted.
- busy  out  1  high from the accepted cmd_strobe until the return to IDLE.
- kbd_clk_i  in  1  keyboard clock pin, asynchronous.
- kbd_data_i  in  1  keyboard data pin, asynchronous.
- kbd_data_oe  out  1  1 = drive the data pin low (open drain); 0 = release (pulled high).

## Operation
- kbd_clk_i and kbd_data_i each pass through a 2-flop synchronizer clocked every clk. A third flop on the clock gives fall/rise detect pulses.
- A single timeout counter (22 bits) clears on every state change and on every detected clock edge. It increments on clk8_en_p. Reaching the state's limit triggers an abort.
- States:
  - IDLE: oe=0. cmd_strobe latches cmd_data into shift register sr, clears bit count bc, and moves to REQ.
  - REQ: oe=1 (data held low = request to send). On the first clk fall, drive sr[7] (oe=~sr[7]), shift sr left and go to TX. REQ_TIMEOUT expiry → ABORT.
  - TX: on each clk rise, bc++. If bc was 7, go to TURN. On each clk fall (bc<8), drive the next MSB. BIT_TIMEOUT → ABORT.
  - TURN: oe=0 (release the line = ready to receive). The first clk fall goes to RX with bc=0. RESP_TIMEOUT → ABORT.
  - RX: oe=0. On each clk rise, sr <= {sr[6:0], synced data} and bc++. On the 8th rise, resp_data<=new sr, pulse resp_strobe, go to IDLE. BIT_TIMEOUT → ABORT.
  - ABORT: for one cycle, oe=0 and timeout=1, then IDLE. resp_data is unchanged.
- Data is MSB first in both directions. The host changes data only while the clock is low; the keyboard samples on rise. The host samples response bits on rise.
- A clock edge and a timeout expiry in the same cycle: the edge wins and the counter clears.
- A clk rise seen in REQ, or a fall seen in TURN before a rise, is handled as follows: a rise in REQ is ignored; the fall in TURN is the defined entry condition.
- Reset mid-transaction: immediate IDLE, oe=0, line released, no strobe.

## Timing
- Reset values: resp_data=8'h00, resp_strobe=0, timeout=0, busy=0, kbd_data_oe=0. Synchronizer flops reset to 1 (idle-high lines).
- busy rises the clk after cmd_strobe. kbd_data_oe rises in the same cycle.
- Pin edge to internal action: 3 clk (2 sync + 1 detect). kbd_data_oe updates 3–4 clk after a pin fall, far inside the ~180 µs low phase.
- resp_strobe is asserted 3 clk after the 8th response clock rise at the pin. busy falls in the same cycle.
- Timeouts are ±1 clk8_en_p tick. A 0.5 s response timeout is 4,000,000 ticks.

## Test plan
- Inquiry: cmd 8'h10. The keyboard model clocks 8 bits (180 µs low / 220 µs high) and samples 0,0,0,1,0,0,0,0 on rise. The model returns 8'h7B. Required: resp_data=8'h7B, one resp_strobe, timeout never pulses.
- Byte 8'hA5 out / 8'h3C in: the sampled sequence is 1,0,1,0,0,1,0,1. During TURN the data pin is high before the first response fall. resp_data=8'h3C.
- No keyboard: cmd_strobe with the clock held high. Required: timeout pulses after 40000±1 ticks, oe=0, busy=0, resp_data unchanged.
- Keyboard stops after 4 command bits. Required: abort after 8000 ticks from the last edge; a following cmd_strobe is accepted normally.
- A cmd_strobe of 8'hFF while busy during TX is ignored. The transmitted byte stays the original one.
- Assert _reset mid-RX (after 5 bits). Required: oe=0, busy=0, no resp_strobe, resp_data=8'h00.
